// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared types and helpers for the PLL ratio sequencer.
// Holds the FSM state enum, SPI frame bit positions and the frame builder.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_DIS,
        S_WAIT_DIS,
        S_TX_EN,
        S_WAIT_EN,
        S_WAIT_LOCK
    } state_e;

    localparam int READ_BIT  = 0;
    localparam int WRITE_BIT = 1;
    localparam int EN_BIT    = 2;
    localparam int RATIO_LSB = 3;
    localparam int RATIO_W   = 10;
    localparam int FIELD_W   = RATIO_LSB + RATIO_W;

    // Only the low FIELD_W bits carry content; the caller zero-extends.
    function automatic logic [FIELD_W-1:0] build_frame(
        input logic               pllen,
        input logic [RATIO_W-1:0] ratio
    );
        logic [FIELD_W-1:0] f;
        f                         = '0;
        f[READ_BIT]               = 1'b0;
        f[WRITE_BIT]              = 1'b1;
        f[EN_BIT]                 = pllen;
        f[RATIO_LSB +: RATIO_W]   = ratio;
        return f;
    endfunction

endpackage

// File: rtl/pll_cfg_seq_lock_monitor.sv
// pll_lock_monitor: qualifies PLL lock and times out the lock wait.
// Ports: clk, rst (sync, active-high), clear, pll_lock -> locked, timeout.
module pll_lock_monitor #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pll_lock,
    output logic locked,
    output logic timeout
);

    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT - 1);

    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        stable_d = stable_q;
        tmo_d    = tmo_q;
        if (clear || !pll_lock) begin
            stable_d = '0;
        end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
        end
        if (clear) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // The current high cycle counts toward the run, so lock is
    // qualified on the LOCK_STABLE-th consecutive high cycle.
    assign locked  = pll_lock && (stable_q >= STABLE_MAX - 1'b1);
    assign timeout = (tmo_q == TMO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            tmo_q    <= '0;
        end else begin
            stable_q <= stable_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: reprograms the PLL ratio over SPI (disable, enable, lock).
// Ports: req_* request side, spi_* to the SPI master, pll_lock, status out.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int FRAME_W      = 512,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [9:0]         req_ratio,
    output logic               req_ready,
    output logic [FRAME_W-1:0] spi_data,
    output logic               spi_start,
    input  logic               spi_finish,
    input  logic               pll_lock,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [9:0]         cur_ratio
);

    localparam int RW = $clog2(MAX_RETRY) + 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [9:0]         ratio_q, ratio_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [FRAME_W-1:0] spi_data_q, spi_data_d;
    logic               spi_start_q, spi_start_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [9:0]         cur_ratio_q, cur_ratio_d;

    logic               mon_clear;
    logic               locked;
    logic               timeout;

    // Counters run only while waiting for lock; every other state
    // holds them at zero so each attempt starts fresh.
    assign mon_clear = (state_q != S_WAIT_LOCK);

    pll_lock_monitor #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE)
    ) u_mon (
        .clk      (clk),
        .rst      (rst),
        .clear    (mon_clear),
        .pll_lock (pll_lock),
        .locked   (locked),
        .timeout  (timeout)
    );

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        retry_d     = retry_q;
        spi_data_d  = spi_data_q;
        spi_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        cur_ratio_d = cur_ratio_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_ratio == 10'd0) begin
                        err_d = 1'b1;
                    end else begin
                        ratio_d = req_ratio;
                        err_d   = 1'b0;
                        retry_d = '0;
                        state_d = S_TX_DIS;
                    end
                end
            end
            S_TX_DIS: state_d = S_WAIT_DIS;
            S_WAIT_DIS: begin
                if (spi_finish) state_d = S_TX_EN;
            end
            S_TX_EN: state_d = S_WAIT_EN;
            S_WAIT_EN: begin
                if (spi_finish) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked) begin
                    cur_ratio_d = ratio_q;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (timeout) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_TX_DIS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame and start are registered on entry to a TX state so
        // both are visible during that TX cycle.
        if (state_d == S_TX_DIS || state_d == S_TX_EN) begin
            spi_start_d = 1'b1;
            spi_data_d  = '0;
            spi_data_d[FIELD_W-1:0] =
                build_frame(state_d == S_TX_EN, ratio_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ratio_q     <= '0;
            retry_q     <= '0;
            spi_data_q  <= '0;
            spi_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_ratio_q <= '0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            retry_q     <= retry_d;
            spi_data_q  <= spi_data_d;
            spi_start_q <= spi_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_ratio_q <= cur_ratio_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign spi_data  = spi_data_q;
    assign spi_start = spi_start_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cur_ratio = cur_ratio_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq: randomized self-checking bench for pll_cfg_seq.
// Expected event times come from a timeline model of the request flow.
module tb_pll_cfg_seq;

    localparam int FW = 512;
    localparam int LT = 300;
    localparam int LS = 16;
    localparam int MR = 3;
    localparam int NW = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [9:0]    req_ratio;
    logic          req_ready;
    logic [FW-1:0] spi_data;
    logic          spi_start;
    logic          spi_finish;
    logic          pll_lock;
    logic          busy;
    logic          done;
    logic          err;
    logic [9:0]    cur_ratio;

    always #5 clk = ~clk;

    pll_cfg_seq #(
        .FRAME_W      (FW),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .MAX_RETRY    (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ratio  (req_ratio),
        .req_ready  (req_ready),
        .spi_data   (spi_data),
        .spi_start  (spi_start),
        .spi_finish (spi_finish),
        .pll_lock   (pll_lock),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_ratio  (cur_ratio)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    bit         wave [NW];
    int         exp_start [$];
    logic [12:0] exp_frame [$];
    int         exp_end;
    bit         exp_ok;
    logic [9:0] cur_model;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] frame_of(input bit en,
                                             input logic [9:0] r);
        int v;
        v = int'(r) * 8 + (en ? 4 : 0) + 2;
        return v[12:0];
    endfunction

    function automatic bit lock_at(input int c);
        if (c < 0 || c >= NW) return 1'b0;
        return wave[c];
    endfunction

    // Timeline relative to the accept edge: cycle 1 is the first
    // cycle after it. SPI finishes L cycles after each start.
    task automatic model(input logic [9:0] r, input int L);
        int t, e, w, run, found, att;
        exp_start.delete();
        exp_frame.delete();
        t   = 1;
        att = 0;
        forever begin
            exp_start.push_back(t);
            exp_frame.push_back(frame_of(1'b0, r));
            e = t + L + 1;
            exp_start.push_back(e);
            exp_frame.push_back(frame_of(1'b1, r));
            w     = e + L + 1;
            run   = 0;
            found = -1;
            for (int c = w; c < w + LT; c++) begin
                run = lock_at(c) ? run + 1 : 0;
                if (run >= LS) begin
                    found = c;
                    break;
                end
            end
            if (found >= 0) begin
                exp_end = found + 1;
                exp_ok  = 1'b1;
                return;
            end
            if (att < MR) begin
                att++;
                t = w + LT;
            end else begin
                exp_end = w + LT;
                exp_ok  = 1'b0;
                return;
            end
        end
    endtask

    task automatic build_wave(input int kind, input int L, input int p);
        int e1, w1, i, hi, lo;
        e1 = L + 2;
        w1 = 2 * L + 3;
        foreach (wave[k]) wave[k] = 1'b0;
        case (kind)
            1: for (int k = e1 + p; k < NW; k++) wave[k] = 1'b1;
            2: begin
                for (int k = w1 + 5; k < w1 + 20; k++) wave[k] = 1'b1;
                for (int k = w1 + 23; k < NW; k++) wave[k] = 1'b1;
            end
            3: begin
                i = 0;
                while (i < NW) begin
                    hi = $urandom_range(1, 24);
                    lo = $urandom_range(1, 8);
                    for (int k = i; k < i + hi && k < NW; k++)
                        wave[k] = 1'b1;
                    i = i + hi + lo;
                end
            end
            4: for (int k = p; k < NW; k++) wave[k] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_req(input logic [9:0] r, input int L,
                           input bit hold, input logic [9:0] nxt);
        int          rel, pend, end_rel, done_rel, ndone;
        int          hi_bits, dbl, dchg, err_busy, n;
        int          s_obs [$];
        logic [12:0] f_obs [$];
        logic        prev_start;
        logic [FW-1:0] prev_data;
        model(r, L);
        check("ready_pre", req_ready, 1);
        req_valid  = 1'b1;
        req_ratio  = r;
        prev_start = 1'b0;
        prev_data  = spi_data;
        pend = -1; end_rel = -1; done_rel = -1; ndone = 0;
        hi_bits = 0; dbl = 0; dchg = 0; err_busy = 0;
        rel = 0;
        while (end_rel < 0 && rel < 4000) begin
            tick();
            rel++;
            if (hold) req_ratio = nxt;
            else req_valid = 1'b0;
            if (spi_start) begin
                s_obs.push_back(rel);
                f_obs.push_back(spi_data[12:0]);
                if (|spi_data[FW-1:13]) hi_bits++;
                pend = rel + L;
            end
            if (spi_start && prev_start) dbl++;
            if (!spi_start && spi_data !== prev_data) dchg++;
            prev_start = spi_start;
            prev_data  = spi_data;
            if (done) begin
                ndone++;
                done_rel = rel;
            end
            if (req_ready) end_rel = rel;
            else if (err) err_busy++;
            spi_finish = (rel == pend);
            pll_lock   = lock_at(rel);
        end
        spi_finish = 1'b0;
        check("end_rel", end_rel, exp_end);
        check("n_start", s_obs.size(), exp_start.size());
        n = (s_obs.size() < exp_start.size()) ? s_obs.size()
                                              : exp_start.size();
        for (int i = 0; i < n; i++) begin
            check("start_rel", s_obs[i], exp_start[i]);
            check("frame", f_obs[i], exp_frame[i]);
        end
        check("frame_hi", hi_bits, 0);
        check("dbl_start", dbl, 0);
        check("data_hold", dchg, 0);
        check("err_busy", err_busy, 0);
        check("n_done", ndone, exp_ok);
        if (exp_ok) check("done_rel", done_rel, exp_end);
        check("err_end", err, !exp_ok);
        check("busy_end", busy, 0);
        if (exp_ok) cur_model = r;
        check("cur_ratio", cur_ratio, cur_model);
    endtask

    task automatic run_zero();
        int nstart, nready;
        check("ready_pre", req_ready, 1);
        req_valid = 1'b1;
        req_ratio = 10'd0;
        tick();
        req_valid = 1'b0;
        check("zero_err", err, 1);
        nstart = 0;
        nready = 0;
        for (int i = 0; i < 20; i++) begin
            if (spi_start) nstart++;
            if (!req_ready || busy) nready++;
            tick();
        end
        check("zero_start", nstart, 0);
        check("zero_ready", nready, 0);
        check("zero_sticky", err, 1);
        check("zero_cur", cur_ratio, cur_model);
    endtask

    task automatic run_reset_mid(input logic [9:0] r, input int L);
        int rel, pend, nst, en_rel, nbad;
        req_valid = 1'b1;
        req_ratio = r;
        rel = 0; pend = -1; nst = 0; en_rel = -1;
        while ((en_rel < 0 || rel < en_rel + 5) && rel < 1000) begin
            tick();
            rel++;
            req_valid = 1'b0;
            if (spi_start) begin
                nst++;
                pend = rel + L;
                if (nst == 2) en_rel = rel;
            end
            spi_finish = (rel == pend);
            pll_lock   = 1'b0;
        end
        check("rstmid_en", nst, 2);
        check("rstmid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_model = 10'd0;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_data", |spi_data, 0);
        check("rst_start", spi_start, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cur", cur_ratio, 0);
        spi_finish = 1'b1;
        tick();
        spi_finish = 1'b0;
        nbad = 0;
        for (int i = 0; i < 30; i++) begin
            if (spi_start || !req_ready) nbad++;
            tick();
        end
        check("stray_finish", nbad, 0);
    endtask

    initial begin
        int L, kind, p;
        logic [9:0] r;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_ratio  = '0;
        spi_finish = 1'b0;
        pll_lock   = 1'b0;
        cur_model  = '0;
        repeat (3) tick();
        check("reset_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_start", spi_start, 0);
        check("reset_data", |spi_data, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_cur", cur_ratio, 0);
        rst = 1'b0;
        repeat (2) tick();

        build_wave(1, 100, 50);
        run_req(10'd6, 100, 1'b0, 10'd0);
        tick();
        build_wave(0, 20, 0);
        run_req(10'h155, 20, 1'b0, 10'd0);
        tick();
        build_wave(2, 30, 0);
        run_req(10'd9, 30, 1'b0, 10'd0);
        tick();
        run_zero();
        run_reset_mid(10'd5, 40);
        build_wave(1, 25, 10);
        run_req(10'd11, 25, 1'b0, 10'd0);
        tick();
        build_wave(1, 15, 20);
        run_req(10'd100, 15, 1'b1, 10'd200);
        build_wave(1, 15, 5);
        run_req(10'd200, 15, 1'b0, 10'd0);

        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(1, 5)) tick();
            r    = 10'($urandom_range(1, 1023));
            L    = $urandom_range(2, 120);
            kind = $urandom_range(0, 4);
            p    = (kind == 4) ? $urandom_range(0, 2000)
                               : $urandom_range(0, 200);
            build_wave(kind, L, p);
            run_req(r, L, 1'b0, 10'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_cfg_seq.md
# pll_cfg_seq

Sequencer that reprograms the PLL ratio through the SPI configuration link. It sits between software/CSR request logic and the SPI master that feeds the PLL map block. On each accepted ratio request it:
- sends a disable frame, then an enable frame;
- waits for the PLL to report a stable lock, retrying on lock timeout;
- reports done or error.

## Interface
Parameters:
- FRAME_W, 512, SPI frame width; must match SPI master DATA_WIDTH.
- LOCK_TIMEOUT, 4096, clk cycles allowed in WAIT_LOCK before a retry.
- LOCK_STABLE, 16, consecutive cycles pll_lock must stay high to count as locked.
- MAX_RETRY, 3, lock attempts after the first before error.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  ratio change request.
- req_ratio  in  10  requested PLL ratio.
- req_ready  out  1  high only in IDLE.
- spi_data  out  FRAME_W  frame presented to the SPI master data_i.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_finish  in  1  one-cycle pulse from the SPI master marking end of transfer.
- pll_lock  in  1  PLL lock indicator, asynchronous to the frame timing.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on successful lock.
- err  out  1  sticky error; cleared on the next accepted request.
- cur_ratio  out  10  last ratio that achieved lock.

## Operation
- Frame layout: bit0 read=0, bit1 write=1, bit2 pllen, bits[12:3] ratio, all other bits 0.
- States and transitions:
  - IDLE: request accepted on req_valid && req_ready. Latch ratio, clear err, go to TX_DIS.
  - TX_DIS: spi_data = frame(pllen=0, ratio); pulse spi_start; go to WAIT_DIS.
  - WAIT_DIS: on spi_finish, go to TX_EN.
  - TX_EN: spi_data = frame(pllen=1, ratio); pulse spi_start; go to WAIT_EN.
  - WAIT_EN: on spi_finish, clear the lock counters and go to WAIT_LOCK.
  - WAIT_LOCK: lock is qualified once pll_lock has been high for LOCK_STABLE consecutive cycles. Any low cycle resets the stable count.
    - On qualified lock: cur_ratio <= ratio; pulse done; go to IDLE.
    - On timeout with retry_cnt < MAX_RETRY: increment retry_cnt; go to TX_DIS.
    - On timeout otherwise: set err; go to IDLE.
- req_ratio == 0 is illegal. It is accepted, sets err the next cycle, sends no SPI frame, and stays in IDLE.
- spi_data holds its last frame value outside TX states. It changes only in TX states.
- spi_finish outside WAIT_DIS/WAIT_EN is ignored.
- req_valid while busy is ignored (req_ready=0). The requester must hold it.

## Timing
- Reset values: state IDLE, req_ready 1, spi_data 0, spi_start 0, busy 0, done 0, err 0, cur_ratio 0, all counters 0.
- spi_start asserts exactly 1 cycle after request acceptance (TX_DIS) and exactly 1 cycle after the disable-frame spi_finish (TX_EN).
- spi_start is never high for two consecutive cycles.
- done rises LOCK_STABLE cycles after the first pll_lock-high cycle of an unbroken run in WAIT_LOCK.
- The timeout counter counts from the first WAIT_LOCK cycle. Timeout fires when the counter reaches LOCK_TIMEOUT-1.
- If qualified lock and timeout fall in the same cycle, lock wins.
- rst asserted in any state returns to IDLE next cycle with the reset values above. An in-flight SPI transfer is abandoned; its later spi_finish is ignored.
- Counter widths are $clog2 of their parameter + 1. Counters saturate and never wrap.

## Structure
- Package pll_cfg_pkg holds:
  - state enum;
  - frame bit-position localparams (READ_BIT=0, WRITE_BIT=1, EN_BIT=2, RATIO_LSB=3, RATIO_W=10);
  - function build_frame(pllen, ratio).
- Sub-module pll_lock_monitor holds the stable counter and timeout counter. It has inputs clk, rst, clear, pll_lock and outputs locked, timeout.
- The top level holds the FSM, the ratio latch and the retry counter.

## Test plan
- Request ratio=6, SPI model pulses finish 100 cycles after each start, lock held high from 50 cycles after the enable frame -> spi_data[12:0] frames 0x032 then 0x036, done pulse, cur_ratio=6, err=0.
- Lock never asserts, MAX_RETRY=3 -> 4 enable frames sent, err=1 after 4×LOCK_TIMEOUT lock-wait windows, cur_ratio unchanged.
- Lock toggles high for 15 cycles then low, then stays high -> no done until 16 consecutive high cycles.
- Request ratio=0 -> err=1, no spi_start, req_ready stays 1.
- rst pulsed in WAIT_EN, then a stray spi_finish -> state IDLE, no spi_start, then a new ratio=11 request completes with frame 0x05E.
- req_valid held during a busy sequence with a different ratio -> second request accepted only after done, on the cycle req_ready returns to 1.
